// File: rtl/en_de_scheduler.sv
// en_de_scheduler: round-robin front end for one shared En_De_Top encode/decode engine.
// One job is in flight at a time. The granted requester's word is registered onto the
// engine input. After ENGINE_LAT cycles the encoded word, the decoded word and a
// round-trip mismatch flag are captured and presented as a response.
// Optional feature macro: EN_DE_SCHED_ERRCNT_EN adds a saturating 16-bit err_count output.
//
// Handshakes:
//   request  - req_ready[i] is a single-cycle, one-hot accept strobe. It is raised only in
//              IDLE, for the chosen requester, when that requester's req_valid is high.
//              The job is taken on the clock edge that ends that cycle.
//   response - resp_valid stays high in RESP, and resp_* hold steady, until the edge where
//              resp_valid && resp_ready are both high. That edge completes the transfer.
//              resp_valid never drops without a handshake, except on reset.
module en_de_scheduler #(
    parameter int DATA_SIZE    = 16,
    parameter int POLY_SIZE    = 16,
    parameter int SCALE_FACTOR = 2,
    parameter int NUM_REQ      = 4,
    parameter int ENGINE_LAT   = 2,
    localparam int EW          = (DATA_SIZE + SCALE_FACTOR) * POLY_SIZE,
    localparam int ID_W        = $clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*DATA_SIZE-1:0]   req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [DATA_SIZE-1:0]           eng_data_in,
    input  logic [EW-1:0]                  eng_encoded,
    input  logic [DATA_SIZE-1:0]           eng_decoded,
    output logic                           resp_valid,
    input  logic                           resp_ready,
    output logic [ID_W-1:0]                resp_id,
    output logic [EW-1:0]                  resp_encoded,
    output logic [DATA_SIZE-1:0]           resp_decoded,
    output logic                           resp_mismatch,
`ifdef EN_DE_SCHED_ERRCNT_EN
    output logic [15:0]                    err_count,
`endif
    output logic                           busy,
    output logic [1:0]                     state_dbg
);

    localparam int CNT_W = (ENGINE_LAT < 2) ? 1 : $clog2(ENGINE_LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t               state, next_state;
    logic [ID_W-1:0]      rr_ptr;
    logic [CNT_W-1:0]     cnt;
    logic [DATA_SIZE-1:0] job_q;
    logic                 found;
    logic [ID_W-1:0]      grant;
    logic [DATA_SIZE-1:0] sel_data;
    logic                 accept;
    logic                 capture;
    logic                 handshake;

    // First valid requester at or after ptr, searching upward and wrapping.
    // The loop runs from the far end back to the pointer, so the nearest hit is written last and wins.
    function automatic logic [ID_W:0] pick_grant(input logic [NUM_REQ-1:0] v,
                                                 input logic [ID_W-1:0]    ptr);
        logic [ID_W:0] r;
        int            idx;
        r = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (v[idx]) r = {1'b1, ID_W'(idx)};
        end
        return r;
    endfunction

    // Arbitration result and the data word of the chosen requester.
    always_comb begin
        {found, grant} = pick_grant(req_valid, rr_ptr);
        sel_data       = req_data[int'(grant)*DATA_SIZE +: DATA_SIZE];
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= next_state;
    end

    // Next-state logic and per-cycle strobes. req_ready is gated by reset so that it drops as soon as reset is asserted.
    always_comb begin
        next_state = state;
        req_ready  = '0;
        accept     = 1'b0;
        capture    = 1'b0;
        handshake  = 1'b0;
        case (state)
            S_IDLE: begin
                if (found) begin
                    accept     = 1'b1;
                    req_ready  = (NUM_REQ'(1) << grant) & {NUM_REQ{reset}};
                    next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt == CNT_W'(1)) begin
                    capture    = 1'b1;
                    next_state = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    handshake  = 1'b1;
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Datapath: latch the job, count down the engine latency, capture the response, then advance the pointer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr        <= '0;
            cnt           <= '0;
            job_q         <= '0;
            eng_data_in   <= '0;
            resp_id       <= '0;
            resp_encoded  <= '0;
            resp_decoded  <= '0;
            resp_mismatch <= 1'b0;
        end else begin
            if (accept) begin
                job_q       <= sel_data;
                eng_data_in <= sel_data;
                resp_id     <= grant;
                cnt         <= CNT_W'(ENGINE_LAT);
            end
            if (state == S_WAIT) cnt <= cnt - CNT_W'(1);
            if (capture) begin
                resp_encoded  <= eng_encoded;
                resp_decoded  <= eng_decoded;
                resp_mismatch <= (eng_decoded != job_q);
            end
            // The requester just served drops to lowest priority.
            if (handshake) begin
                rr_ptr <= (resp_id == ID_W'(NUM_REQ - 1)) ? '0 : resp_id + ID_W'(1);
            end
        end
    end

`ifdef EN_DE_SCHED_ERRCNT_EN
    // Count responses handed over with a mismatch. The count saturates at all-ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) err_count <= '0;
        else if (handshake && resp_mismatch && (err_count != 16'hFFFF))
            err_count <= err_count + 16'd1;
    end
`endif

    assign resp_valid = (state == S_RESP);
    assign busy       = (state != S_IDLE);
    assign state_dbg  = state;

endmodule
